ysyx_25040111_axi_arbiter: RTL and testbench

- Two-master, one-slave AXI4-Lite arbiter between the core's memory masters and the single SoC memory port.
- M0 is the IFU (read-only). M1 is the LSU (read and write).
- Exactly one transaction is outstanding at a time. The grant is held from request until the R or B response completes.
- A per-transaction timeout returns an error response if the slave never answers, so the core cannot hang.

---
 rtl/ysyx_25040111_axi_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_ysyx_25040111_axi_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_axi_arbiter
//
// Purpose:
//   Two-master, one-slave AXI4-Lite arbiter. M0 is the IFU (read only), M1 is
//   the LSU (read and write). Only one transaction is in flight at a time: the
//   grant is taken in IDLE, held until the R or B response handshakes, and is
//   followed by one mandatory IDLE cycle. A per-transaction timeout forces an
//   error response (resp=2'b11, rdata=0) if the slave never answers, and sets
//   the sticky timeout_err flag.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   m0_ar*/m0_r*        IFU read-address / read-data channels
//   m1_ar*/m1_r*        LSU read-address / read-data channels
//   m1_aw*/m1_w*/m1_b*  LSU write-address / write-data / write-response
//   s_*                 slave-side mirror of the above, directions inverted
//   timeout_err         sticky, set whenever a forced timeout response is driven
//   dbg_state           current arbiter state: 0 IDLE, 1 IFU_RD, 2 LSU_RD,
//                       3 LSU_WR
//
// Handshake semantics: every channel uses AXI valid/ready; a transfer happens
// on a rising edge where both valid and ready are 1. A source holds valid and
// payload stable until that edge; ready may depend combinationally on valid.
// ---------------------------------------------------------------------------
module ysyx_25040111_axi_arbiter #(
    parameter int LSU_FIRST = 1,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    // IFU read channels
    input  logic        m0_arvalid,
    input  logic [31:0] m0_araddr,
    input  logic [2:0]  m0_arsize,
    output logic        m0_arready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    input  logic        m0_rready,

    // LSU read channels
    input  logic        m1_arvalid,
    input  logic [31:0] m1_araddr,
    input  logic [2:0]  m1_arsize,
    output logic        m1_arready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    input  logic        m1_rready,

    // LSU write channels
    input  logic        m1_awvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [2:0]  m1_awsize,
    output logic        m1_awready,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [1:0]  m1_bresp,
    input  logic        m1_bready,

    // Slave side
    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    output logic [2:0]  s_arsize,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    output logic        s_rready,
    output logic        s_awvalid,
    output logic [31:0] s_awaddr,
    output logic [2:0]  s_awsize,
    input  logic        s_awready,
    output logic        s_wvalid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_wready,
    input  logic        s_bvalid,
    input  logic [1:0]  s_bresp,
    output logic        s_bready,

    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam bit               TO_EN  = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Response valid from the slave for the channel that closes the current
    // transaction (B for writes, R for reads).
    logic             slv_resp_valid;
    // Forced error response this cycle. A real response in the same cycle
    // suppresses it, so a late-but-valid answer is never replaced by an error.
    logic             to_hit;

    always_comb begin
        slv_resp_valid = (state_q == LSU_WR) ? s_bvalid : s_rvalid;
        to_hit = TO_EN && (state_q != IDLE) && (cnt_q == TO_VAL) && !slv_resp_valid;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | to_hit;

        case (state_q)
            IDLE: begin
                // Counter is zero on the first granted cycle.
                cnt_d = '0;
                if (LSU_FIRST != 0) begin
                    if (m1_awvalid)      state_d = LSU_WR;
                    else if (m1_arvalid) state_d = LSU_RD;
                    else if (m0_arvalid) state_d = IFU_RD;
                end else begin
                    if (m0_arvalid)      state_d = IFU_RD;
                    else if (m1_awvalid) state_d = LSU_WR;
                    else if (m1_arvalid) state_d = LSU_RD;
                end
            end
            IFU_RD: begin
                if (cnt_q != TO_VAL) cnt_d = cnt_q + CNT_W'(1);
                if ((s_rvalid || to_hit) && m0_rready) state_d = IDLE;
            end
            LSU_RD: begin
                if (cnt_q != TO_VAL) cnt_d = cnt_q + CNT_W'(1);
                if ((s_rvalid || to_hit) && m1_rready) state_d = IDLE;
            end
            LSU_WR: begin
                if (cnt_q != TO_VAL) cnt_d = cnt_q + CNT_W'(1);
                if ((s_bvalid || to_hit) && m1_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Channel routing. Everything not belonging to the granted master is 0.
    // During a forced timeout cycle the slave-side valids and the request
    // readys are gated so nothing new is issued while the error is returned.
    // ------------------------------------------------------------------
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = 32'h0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = 32'h0;
        m1_rresp   = 2'b00;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_araddr   = 32'h0;
        s_arsize   = 3'b000;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = 32'h0;
        s_awsize   = 3'b000;
        s_wvalid   = 1'b0;
        s_wdata    = 32'h0;
        s_wstrb    = 4'h0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;

        case (state_q)
            IDLE: begin
                // Sink any stray or late response left over from an
                // abandoned transaction.
                s_rready = 1'b1;
                s_bready = 1'b1;
            end
            IFU_RD: begin
                s_arvalid  = m0_arvalid & ~to_hit;
                s_araddr   = m0_araddr;
                s_arsize   = m0_arsize;
                m0_arready = s_arready & ~to_hit;
                s_rready   = m0_rready;
                m0_rvalid  = s_rvalid | to_hit;
                m0_rdata   = to_hit ? 32'h0 : s_rdata;
                m0_rresp   = to_hit ? 2'b11 : s_rresp;
            end
            LSU_RD: begin
                s_arvalid  = m1_arvalid & ~to_hit;
                s_araddr   = m1_araddr;
                s_arsize   = m1_arsize;
                m1_arready = s_arready & ~to_hit;
                s_rready   = m1_rready;
                m1_rvalid  = s_rvalid | to_hit;
                m1_rdata   = to_hit ? 32'h0 : s_rdata;
                m1_rresp   = to_hit ? 2'b11 : s_rresp;
            end
            LSU_WR: begin
                // AW and W are passed independently; either order or both
                // at once is forwarded as presented.
                s_awvalid  = m1_awvalid & ~to_hit;
                s_awaddr   = m1_awaddr;
                s_awsize   = m1_awsize;
                m1_awready = s_awready & ~to_hit;
                s_wvalid   = m1_wvalid & ~to_hit;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wlast    = m1_wlast;
                m1_wready  = s_wready & ~to_hit;
                s_bready   = m1_bready;
                m1_bvalid  = s_bvalid | to_hit;
                m1_bresp   = to_hit ? 2'b11 : s_bresp;
            end
            default: ;
        endcase
    end

    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_25040111_axi_arbiter (LSU_FIRST=1, TIMEOUT=8).
// A transaction-level model tracks who owns the slave and since which cycle;
// every cycle the DUT outputs are compared with what the routing rules imply.
// Directed sequences add hand-computed literal checks and a read-data
// scoreboard.
// ---------------------------------------------------------------------------
module tb_ysyx_25040111_axi_arbiter;

    localparam int LSU_F = 1;
    localparam int TO    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
    logic        m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [2:0]  m1_awsize;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [2:0]  s_arsize;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic        s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [2:0]  s_awsize;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    ysyx_25040111_axi_arbiter #(.LSU_FIRST(LSU_F), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
        .m1_awready(m1_awready), .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arsize(s_arsize),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- counters / check helper ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // owner: 0 none, 1 IFU read, 2 LSU read, 3 LSU write
    int cyc = 0;
    int owner = 0;
    int t_start = 0;
    bit m_err = 1'b0;
    bit model_ready = 1'b0;

    function automatic bit timed_out(input int own, input int now, input int start);
        bit rv;
        rv = (own == 3) ? s_bvalid : s_rvalid;
        return (own != 0) && (TO != 0) && ((now - start) >= TO) && !rv;
    endfunction

    always @(posedge clk) begin
        bit to;
        bit rr;
        bit rv;
        if (!rst_n) begin
            owner = 0;
            m_err = 1'b0;
        end else if (owner == 0) begin
            if (LSU_F != 0) begin
                if (m1_awvalid)      owner = 3;
                else if (m1_arvalid) owner = 2;
                else if (m0_arvalid) owner = 1;
            end else begin
                if (m0_arvalid)      owner = 1;
                else if (m1_awvalid) owner = 3;
                else if (m1_arvalid) owner = 2;
            end
            if (owner != 0) t_start = cyc + 1;
        end else begin
            to = timed_out(owner, cyc, t_start);
            rv = (owner == 3) ? s_bvalid : s_rvalid;
            rr = (owner == 1) ? m0_rready : (owner == 2) ? m1_rready : m1_bready;
            if (to) m_err = 1'b1;
            if ((rv || to) && rr) owner = 0;
        end
        cyc++;
        model_ready = 1'b1;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [35:0] e_m0;
        logic [40:0] e_m1;
        logic [36:0] e_sar;
        logic [74:0] e_saw;
        bit to;
        logic [31:0] got;
        if (model_ready) begin
            to = timed_out(owner, cyc, t_start);
            e_m0  = '0;
            e_m1  = '0;
            e_sar = '0;
            e_saw = '0;
            case (owner)
                0: begin
                    e_sar = {1'b0, 32'h0, 3'b0, 1'b1};
                    e_saw = {1'b0, 32'h0, 3'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1};
                end
                1: begin
                    e_sar = {m0_arvalid & !to, m0_araddr, m0_arsize, m0_rready};
                    e_m0  = {s_arready & !to, s_rvalid | to, to ? 32'h0 : s_rdata,
                             to ? 2'b11 : s_rresp};
                end
                2: begin
                    e_sar = {m1_arvalid & !to, m1_araddr, m1_arsize, m1_rready};
                    e_m1  = {s_arready & !to, s_rvalid | to, to ? 32'h0 : s_rdata,
                             to ? 2'b11 : s_rresp, 1'b0, 1'b0, 1'b0, 2'b00};
                end
                default: begin
                    e_saw = {m1_awvalid & !to, m1_awaddr, m1_awsize, m1_wvalid & !to,
                             m1_wdata, m1_wstrb, m1_wlast, m1_bready};
                    e_m1  = {1'b0, 1'b0, 32'h0, 2'b00, s_awready & !to,
                             s_wready & !to, s_bvalid | to, to ? 2'b11 : s_bresp};
                end
            endcase
            chk("m0_out", {m0_arready, m0_rvalid, m0_rdata, m0_rresp}, e_m0);
            chk("m1_out", {m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_awready,
                           m1_wready, m1_bvalid, m1_bresp}, e_m1);
            chk("s_ar_r", {s_arvalid, s_araddr, s_arsize, s_rready}, e_sar);
            chk("s_aw_w_b", {s_awvalid, s_awaddr, s_awsize, s_wvalid, s_wdata,
                             s_wstrb, s_wlast, s_bready}, e_saw);
            chk("timeout_err", timeout_err, m_err);
            chk("state", dbg_state, owner[1:0]);

            // Read-data scoreboard: every delivered read beat must be expected.
            if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
                got = m0_rvalid ? m0_rdata : m1_rdata;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_read", got, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_rdata", got, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = 0; m0_arsize = 0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_arsize = 0; m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = 0; m1_awsize = 0;
        m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    endtask

    // Slave read response for one cycle; bench expects the given data.
    task automatic slave_r(input logic [31:0] d);
        s_rvalid = 1; s_rdata = d; s_rresp = 2'b00;
        exp_q.push_back(d);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        clear_inputs();
        rst_n = 0;
        step(); step();
        #1;
        chk("reset_state", dbg_state, 2'd0);
        chk("reset_err", timeout_err, 1'b0);
        chk("reset_s_rready", s_rready, 1'b1);
        rst_n = 1;
        step();

        // 1) IFU read alone, slave answers 3 cycles after AR.
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arsize = 3'd2; m0_rready = 1;
        s_arready = 1; m1_rready = 1; m1_bready = 1;
        step();
        #1;
        chk("ifu_state", dbg_state, 2'd1);
        chk("ifu_s_araddr", s_araddr, 32'h8000_0000);
        step();
        m0_arvalid = 0;
        step(); step();
        slave_r(32'hDEAD_BEEF);
        #1;
        chk("ifu_rvalid", m0_rvalid, 1'b1);
        chk("ifu_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("ifu_m1_quiet", m1_rvalid, 1'b0);
        step();
        s_rvalid = 0;
        #1;
        chk("ifu_back_idle", dbg_state, 2'd0);

        // 2) Collision: LSU read wins, IFU follows with unchanged address.
        m0_arvalid = 1; m0_araddr = 32'h8000_0010;
        m1_arvalid = 1; m1_araddr = 32'h0F00_0100; m1_arsize = 3'd2;
        step();
        #1;
        chk("col_lsu_first", dbg_state, 2'd2);
        chk("col_s_araddr", s_araddr, 32'h0F00_0100);
        chk("col_m0_arready", m0_arready, 1'b0);
        step();
        m1_arvalid = 0;
        step();
        slave_r(32'h1111_2222);
        step();
        s_rvalid = 0;
        step();
        #1;
        chk("col_ifu_next", dbg_state, 2'd1);
        chk("col_ifu_addr", s_araddr, 32'h8000_0010);
        step();
        m0_arvalid = 0;
        slave_r(32'h3333_4444);
        step();
        s_rvalid = 0;

        // 3) LSU write with an IFU request waiting.
        m1_awvalid = 1; m1_awaddr = 32'h0F00_0004; m1_awsize = 3'd2;
        m1_wvalid = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wlast = 1;
        s_awready = 1; s_wready = 1;
        m0_arvalid = 1; m0_araddr = 32'h8000_0020;
        step();
        #1;
        chk("wr_state", dbg_state, 2'd3);
        chk("wr_s_aw", {s_awvalid, s_awaddr, s_awsize}, {1'b1, 32'h0F00_0004, 3'd2});
        chk("wr_s_w", {s_wvalid, s_wdata, s_wstrb, s_wlast}, {1'b1, 32'h1234_5678, 4'hF, 1'b1});
        chk("wr_m0_arready", m0_arready, 1'b0);
        step();
        m1_awvalid = 0; m1_wvalid = 0;
        step();
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        chk("wr_bvalid", {m1_bvalid, m1_bresp}, {1'b1, 2'b00});
        step();
        s_bvalid = 0;
        step();
        step();
        m0_arvalid = 0;
        slave_r(32'h5555_6666);
        step();
        s_rvalid = 0;

        // 4) Timeout: slave never answers the IFU read.
        m0_arvalid = 1; m0_araddr = 32'h8000_0040;
        step();                 // granted cycle 1
        step();                 // cycle 2, AR accepted
        m0_arvalid = 0;
        repeat (6) step();      // cycle 8
        #1;
        chk("to_not_yet", m0_rvalid, 1'b0);
        step();                 // cycle 9
        exp_q.push_back(32'h0);
        #1;
        chk("to_forced", {m0_rvalid, m0_rdata, m0_rresp}, {1'b1, 32'h0, 2'b11});
        chk("to_s_arvalid", s_arvalid, 1'b0);
        step();
        #1;
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_idle", dbg_state, 2'd0);
        // Next request is served normally; the flag is sticky.
        m1_arvalid = 1; m1_araddr = 32'h0F00_0200;
        step();
        step();
        m1_arvalid = 0;
        slave_r(32'h7777_8888);
        #1;
        chk("to_next_rdata", m1_rdata, 32'h7777_8888);
        step();
        s_rvalid = 0;
        #1;
        chk("to_err_sticky", timeout_err, 1'b1);

        // Reset clears the sticky flag.
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("rst_err_clear", timeout_err, 1'b0);

        // 5) Real response exactly on the timeout cycle wins.
        m0_arvalid = 1; m0_araddr = 32'h8000_0080;
        step();
        step();
        m0_arvalid = 0;
        repeat (7) step();      // cycle 9
        slave_r(32'hA5A5_A5A5);
        #1;
        chk("race_rdata", {m0_rvalid, m0_rdata, m0_rresp}, {1'b1, 32'hA5A5_A5A5, 2'b00});
        step();
        s_rvalid = 0;
        #1;
        chk("race_no_err", timeout_err, 1'b0);

        // 6) Reset in the middle of an LSU read; late response is sunk.
        m1_arvalid = 1; m1_araddr = 32'h0F00_0300;
        step();
        step();
        m1_arvalid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("mid_rst_state", dbg_state, 2'd0);
        s_rvalid = 1; s_rdata = 32'hBADB_AD00;
        #1;
        chk("late_sunk", {s_rready, m0_rvalid, m1_rvalid}, {1'b1, 1'b0, 1'b0});
        step();
        s_rvalid = 0;
        step(); step();

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
